step_tracker: RTL and testbench

Activity-tracking core that consumes the divided seconds clock `slowClk` and a raw step pulse, and produces the step, distance and activity statistics shown on the display. It sits directly downstream of the clock divider. It runs entirely on the fast clock and treats `slowClk` as a data input, synchronising it and edge-detecting it rather than clocking logic from it.

---
 rtl/step_tracker.sv | 129 ++++++++++++
 tb/tb_step_tracker.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/step_tracker.sv
// Activity-tracking core: counts steps, half-mile distance, over-rate seconds and
// time spent in sustained high-activity runs. slowClk is sampled as data on CLK.
module step_tracker #(
  parameter int unsigned HALF_MILE_STEPS = 1024,
  parameter int unsigned STEP_SAT        = 9999,
  parameter int unsigned OVER_RATE       = 32,
  parameter int unsigned WIN_SEC         = 9,
  parameter int unsigned HI_RATE         = 64,
  parameter int unsigned HI_MIN_SEC      = 60
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        slowClk,
  input  logic        pulse,
  output logic [13:0] totalSteps,
  output logic [7:0]  distHalf,
  output logic [3:0]  overSec,
  output logic [15:0] hiActSec,
  output logic        secTick
);

  typedef enum logic [1:0] {IDLE, RUN, QUAL} st_t;

  localparam logic [11:0] HALF  = 12'(HALF_MILE_STEPS);
  localparam logic [13:0] SSAT  = 14'(STEP_SAT);
  localparam logic [7:0]  OVR   = 8'(OVER_RATE);
  localparam logic [3:0]  WIN   = 4'(WIN_SEC);
  localparam logic [7:0]  HIR   = 8'(HI_RATE);
  localparam logic [15:0] HMIN  = 16'(HI_MIN_SEC);

  logic        p1, p2, p3, s1, s2, s3;
  logic [1:0]  arm;
  logic        armed, step_ev, sec_ev;
  logic [10:0] modCnt;
  logic [7:0]  rateCnt, r;
  logic [3:0]  secIdx;
  logic [15:0] runLen, run_n, hi_add;
  logic [16:0] hi_sum;
  logic        hi;
  st_t         st, st_n;

  // Events stay masked for the first cycles so inputs held high across reset
  // release fill the synchronisers without producing an edge.
  assign armed   = (arm == 2'd3);
  assign step_ev = armed & p2 & ~p3;
  assign sec_ev  = armed & s2 & ~s3;
  assign secTick = sec_ev;

  assign r      = (rateCnt == 8'hFF) ? 8'hFF : rateCnt + {7'd0, step_ev};
  assign hi     = (r >= HIR);
  assign hi_sum = {1'b0, hiActSec} + {1'b0, hi_add};

  always_comb begin
    st_n   = st;
    run_n  = runLen;
    hi_add = '0;
    if (sec_ev) begin
      case (st)
        IDLE: if (hi) begin
          run_n = 16'd1;
          if (HMIN == 16'd1) begin
            st_n   = QUAL;
            hi_add = 16'd1;
          end else st_n = RUN;
        end
        RUN: if (hi) begin
          run_n = runLen + 16'd1;
          if (runLen + 16'd1 == HMIN) begin
            st_n   = QUAL;
            hi_add = HMIN;
          end
        end else begin
          run_n = '0;
          st_n  = IDLE;
        end
        QUAL: if (hi) hi_add = 16'd1;
        else begin
          run_n = '0;
          st_n  = IDLE;
        end
        default: begin
          run_n = '0;
          st_n  = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      {p1, p2, p3, s1, s2, s3} <= '0;
      arm        <= '0;
      totalSteps <= '0;
      distHalf   <= '0;
      overSec    <= '0;
      hiActSec   <= '0;
      modCnt     <= '0;
      rateCnt    <= '0;
      secIdx     <= '0;
      runLen     <= '0;
      st         <= IDLE;
    end else begin
      {p1, p2, p3} <= {pulse, p1, p2};
      {s1, s2, s3} <= {slowClk, s1, s2};
      if (!armed) arm <= arm + 2'd1;
      st       <= st_n;
      runLen   <= run_n;
      hiActSec <= hi_sum[16] ? 16'hFFFF : hi_sum[15:0];

      if (step_ev) begin
        if (totalSteps != SSAT) totalSteps <= totalSteps + 14'd1;
        // distance keeps advancing after totalSteps saturates
        if ({1'b0, modCnt} + 12'd1 == HALF) begin
          modCnt <= '0;
          if (distHalf != 8'hFF) distHalf <= distHalf + 8'd1;
        end else modCnt <= modCnt + 11'd1;
      end

      if (sec_ev) begin
        rateCnt <= '0;
        if (secIdx < WIN) begin
          secIdx <= secIdx + 4'd1;
          if (r > OVR) overSec <= overSec + 4'd1;
        end
      end else if (step_ev && rateCnt != 8'hFF) rateCnt <= rateCnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_step_tracker.sv
// Directed bench for step_tracker: stimulus pushes expected per-second results,
// a monitor pops them on each secTick and compares the registered statistics.
module tb_step_tracker;
  logic        CLK = 1'b0, RESET = 1'b0, slowClk = 1'b0, pulse = 1'b0;
  logic [13:0] totalSteps;
  logic [7:0]  distHalf;
  logic [3:0]  overSec;
  logic [15:0] hiActSec;
  logic        secTick;

  step_tracker #(.HI_MIN_SEC(3)) dut (
    .CLK(CLK), .RESET(RESET), .slowClk(slowClk), .pulse(pulse),
    .totalSteps(totalSteps), .distHalf(distHalf), .overSec(overSec),
    .hiActSec(hiActSec), .secTick(secTick)
  );

  always #5 CLK = ~CLK;

  typedef struct { int ts; int dh; int ov; int hi; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  int nsteps = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: a tick is consumed on the next rising edge, compare just after it
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (secTick === 1'b1) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_secTick: got tick with no second issued at %0t", $time);
          @(negedge CLK);
        end else begin
          e = q.pop_front();
          @(posedge CLK); #1;
          chk("sec_overSec", int'(overSec), e.ov);
          chk("sec_hiActSec", int'(hiActSec), e.hi);
          chk("sec_totalSteps", int'(totalSteps), e.ts);
          chk("sec_distHalf", int'(distHalf), e.dh);
          @(negedge CLK);
          chk("secTick_width", int'(secTick), 0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    chk("rst_totalSteps", int'(totalSteps), 0);
    chk("rst_distHalf", int'(distHalf), 0);
    chk("rst_overSec", int'(overSec), 0);
    chk("rst_hiActSec", int'(hiActSec), 0);
    chk("rst_secTick", int'(secTick), 0);
    nsteps = 0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
  endtask

  task automatic step();
    @(negedge CLK) pulse = 1'b1;
    @(negedge CLK);
    @(negedge CLK) pulse = 1'b0;
    @(negedge CLK);
  endtask

  task automatic push(input int ov, input int hi);
    exp_t e;
    e.ts = (nsteps > 9999) ? 9999 : nsteps;
    e.dh = nsteps / 1024;
    e.ov = ov;
    e.hi = hi;
    q.push_back(e);
  endtask

  task automatic close_sec();
    @(negedge CLK) slowClk = 1'b1;
    @(negedge CLK);
    @(negedge CLK) slowClk = 1'b0;
    @(negedge CLK);
    repeat (3) @(negedge CLK);
  endtask

  task automatic do_sec(input int rate, input int ov, input int hi);
    repeat (rate) step();
    nsteps += rate;
    push(ov, hi);
    close_sec();
  endtask

  int win_rate [12] = '{33, 32, 40, 0, 50, 33, 31, 100, 34, 99, 99, 99};
  int win_ov   [12] = '{1, 1, 2, 2, 3, 4, 4, 5, 6, 6, 6, 6};
  int win_hi   [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3};
  int run_rate [8]  = '{64, 64, 63, 64, 64, 64, 70, 10};
  int run_ov   [8]  = '{1, 2, 3, 4, 5, 6, 7, 7};
  int run_hi   [8]  = '{0, 0, 0, 0, 0, 3, 4, 4};

  initial begin
    // inputs held high across reset release must not create events
    pulse = 1'b1; slowClk = 1'b1;
    do_reset();
    repeat (6) @(negedge CLK);
    chk("held_high_totalSteps", int'(totalSteps), 0);
    pulse = 1'b0; slowClk = 1'b0;
    repeat (4) @(negedge CLK);
    repeat (10) step();
    repeat (2) @(negedge CLK);
    chk("ten_steps_total", int'(totalSteps), 10);
    chk("ten_steps_dist", int'(distHalf), 0);

    // overSec window: only the first nine seconds count
    do_reset();
    for (int i = 0; i < 12; i++) do_sec(win_rate[i], win_ov[i], win_hi[i]);

    // 33rd step coincides with the second boundary
    do_reset();
    repeat (32) step();
    nsteps += 33;
    push(1, 0);
    @(negedge CLK) begin pulse = 1'b1; slowClk = 1'b1; end
    @(negedge CLK);
    @(negedge CLK) begin pulse = 1'b0; slowClk = 1'b0; end
    @(negedge CLK);
    repeat (3) @(negedge CLK);
    do_sec(32, 1, 0);

    // high-activity runs with a three-second minimum
    do_reset();
    for (int i = 0; i < 8; i++) do_sec(run_rate[i], run_ov[i], run_hi[i]);

    // reset in RUN: the run must start over afterwards
    do_reset();
    do_sec(64, 1, 0);
    do_sec(64, 2, 0);
    do_reset();
    do_sec(64, 1, 0);
    do_sec(64, 2, 0);
    do_sec(64, 3, 3);

    // saturation of totalSteps while distance keeps counting
    do_reset();
    repeat (10250) step();
    repeat (2) @(negedge CLK);
    chk("sat_totalSteps", int'(totalSteps), 9999);
    chk("sat_distHalf", int'(distHalf), 10);
    step();
    repeat (2) @(negedge CLK);
    chk("sat_plus1_totalSteps", int'(totalSteps), 9999);
    chk("sat_plus1_distHalf", int'(distHalf), 10);

    repeat (10) @(negedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
